// File: rtl/pc_predict_unit_pkg.sv
// Shared types for the fetch-stage PC / branch predictor slice.
//   ctr_t     : 2-bit saturating direction counter (MSB = predict taken)
//   ctr_next  : saturating train step of a counter toward the resolved direction
package pc_predict_unit_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  // Counter value written when a taken branch is first allocated.
  localparam ctr_t CTR_ALLOC = WEAK_T;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken)
      return (c == STRONG_T) ? STRONG_T : ctr_t'(c + 2'd1);
    else
      return (c == STRONG_NT) ? STRONG_NT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pc_predict_unit_if.sv
// Fetch / execute-feedback bundle of the PC predict unit.
//   Fetch side : ihit, stall (in to unit); i_addr, pred_taken, pred_target (out)
//   Redirect   : redirect_valid, redirect_pc
//   Training   : update_valid, update_pc, update_taken, update_target
// slave = predict unit, master = pipeline driving it.
interface pc_predict_unit_if #(
  parameter int unsigned PC_W = 32
);
  logic            ihit;
  logic            stall;
  logic [PC_W-1:0] i_addr;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            update_valid;
  logic [PC_W-1:0] update_pc;
  logic            update_taken;
  logic [PC_W-1:0] update_target;

  modport slave (
    input  ihit, stall, redirect_valid, redirect_pc,
           update_valid, update_pc, update_taken, update_target,
    output i_addr, pred_taken, pred_target
  );

  modport master (
    output ihit, stall, redirect_valid, redirect_pc,
           update_valid, update_pc, update_taken, update_target,
    input  i_addr, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_predict_unit_btb_table.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Addresses are passed as word addresses (byte address >> 2).
//   CLK, nRST         : clock, async active-low reset (clears valid bits only)
//   i_rd_word         : lookup word address (combinational read)
//   o_rd_hit          : valid entry with matching tag
//   o_rd_ctr          : counter of the indexed entry
//   o_rd_target       : stored byte target (always word aligned)
//   i_wr_valid        : train with a resolved control-flow instruction
//   i_wr_word         : word address of the resolved instruction
//   i_wr_taken        : resolved direction
//   i_wr_target_word  : resolved taken target (word address)
module btb_table
  import pc_predict_unit_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BTB_DEPTH = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [PC_W-3:0] i_rd_word,
  output logic            o_rd_hit,
  output ctr_t            o_rd_ctr,
  output logic [PC_W-1:0] o_rd_target,
  input  logic            i_wr_valid,
  input  logic [PC_W-3:0] i_wr_word,
  input  logic            i_wr_taken,
  input  logic [PC_W-3:0] i_wr_target_word
);

  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = PC_W - 2 - IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [PC_W-3:0]   target;
    ctr_t              ctr;
  } btb_data_t;

  logic [BTB_DEPTH-1:0] r_valid;
  btb_data_t            r_data [BTB_DEPTH];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  btb_data_t        w_rd_entry;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;
  logic             w_wr_hit;

  assign w_rd_idx    = i_rd_word[IDX_W-1:0];
  assign w_rd_tag    = i_rd_word[PC_W-3:IDX_W];
  assign w_rd_entry  = r_data[w_rd_idx];
  assign o_rd_hit    = r_valid[w_rd_idx] && (w_rd_entry.tag == w_rd_tag);
  assign o_rd_ctr    = w_rd_entry.ctr;
  assign o_rd_target = {w_rd_entry.target, 2'b00};

  assign w_wr_idx = i_wr_word[IDX_W-1:0];
  assign w_wr_tag = i_wr_word[PC_W-3:IDX_W];
  assign w_wr_hit = r_valid[w_wr_idx] && (r_data[w_wr_idx].tag == w_wr_tag);

  // Only the valid bits carry a reset; payload is don't-care while invalid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_valid <= '0;
    else if (i_wr_valid && !w_wr_hit && i_wr_taken)
      r_valid[w_wr_idx] <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (i_wr_valid) begin
      if (w_wr_hit) begin
        r_data[w_wr_idx].ctr <= ctr_next(r_data[w_wr_idx].ctr, i_wr_taken);
        if (i_wr_taken)
          r_data[w_wr_idx].target <= i_wr_target_word;
      end else if (i_wr_taken) begin
        // Allocation replaces whatever aliased entry lived at this index.
        r_data[w_wr_idx] <= '{tag: w_wr_tag, target: i_wr_target_word, ctr: CTR_ALLOC};
      end
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage program counter with BTB-based next-PC prediction.
//   CLK, nRST : clock, async active-low reset (PC <= RESET_PC, BTB invalidated)
//   bus       : pc_predict_unit_if slave -- fetch address and prediction out,
//               execute-stage redirect and training in
// Next PC priority: redirect > (stall or no ihit => hold) > predicted target.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     BTB_DEPTH = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input logic               CLK,
  input logic               nRST,
  pc_predict_unit_if.slave  bus
);

  logic [PC_W-1:0] r_pc;
  logic            w_hit;
  ctr_t            w_ctr;
  logic [PC_W-1:0] w_btb_target;
  logic [PC_W-1:0] w_seq_pc;
  logic            w_pred_taken;
  logic [PC_W-1:0] w_pred_target;
  logic            w_unused_lsbs;

  btb_table #(
    .PC_W      (PC_W),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .CLK              (CLK),
    .nRST             (nRST),
    .i_rd_word        (r_pc[PC_W-1:2]),
    .o_rd_hit         (w_hit),
    .o_rd_ctr         (w_ctr),
    .o_rd_target      (w_btb_target),
    .i_wr_valid       (bus.update_valid),
    .i_wr_word        (bus.update_pc[PC_W-1:2]),
    .i_wr_taken       (bus.update_taken),
    .i_wr_target_word (bus.update_target[PC_W-1:2])
  );

  // Byte-offset bits of incoming addresses are deliberately discarded.
  assign w_unused_lsbs = ^{bus.redirect_pc[1:0], bus.update_pc[1:0], bus.update_target[1:0]};

  assign w_seq_pc      = r_pc + PC_W'(32'd4);
  assign w_pred_taken  = w_hit && w_ctr[1];
  assign w_pred_target = w_pred_taken ? w_btb_target : w_seq_pc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_pc <= {RESET_PC[PC_W-1:2], 2'b00};
    else if (bus.redirect_valid)
      r_pc <= {bus.redirect_pc[PC_W-1:2], 2'b00};
    else if (bus.ihit && !bus.stall)
      r_pc <= w_pred_target;
  end

  assign bus.i_addr      = r_pc;
  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_pred_target;

endmodule

// File: tb/tb_pc_predict_unit.sv
module tb_pc_predict_unit;
  logic CLK;
  logic nRST;
  int   vectors;
  int   miscompares;

  pc_predict_unit_if #(.PC_W(32)) bus ();

  pc_predict_unit #(
    .PC_W      (32),
    .BTB_DEPTH (16),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.update_valid  = 1'b1;
    bus.update_pc     = pc;
    bus.update_taken  = taken;
    bus.update_target = tgt;
  endtask

  task automatic no_upd();
    bus.update_valid  = 1'b0;
    bus.update_taken  = 1'b0;
    bus.update_pc     = '0;
    bus.update_target = '0;
  endtask

  task automatic redir(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
  endtask

  task automatic no_redir();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nRST        = 1'b0;
    bus.ihit    = 1'b0;
    bus.stall   = 1'b0;
    no_redir();
    no_upd();

    // Reset state
    #1;
    chk("rst_addr", bus.i_addr, 32'h0);
    chk("rst_ptaken", {31'b0, bus.pred_taken}, 32'h0);
    chk("rst_ptarget", bus.pred_target, 32'h4);
    #11;
    nRST = 1'b1;

    // Sequential fetch 0,4,8,C,10
    bus.ihit = 1'b1;
    tick(); chk("seq_4", bus.i_addr, 32'h4);   chk("seq_pt4", {31'b0, bus.pred_taken}, 32'h0);
    tick(); chk("seq_8", bus.i_addr, 32'h8);   chk("seq_pt8", {31'b0, bus.pred_taken}, 32'h0);
    tick(); chk("seq_c", bus.i_addr, 32'hC);   chk("seq_ptc", {31'b0, bus.pred_taken}, 32'h0);
    tick(); chk("seq_10", bus.i_addr, 32'h10); chk("seq_pt10", {31'b0, bus.pred_taken}, 32'h0);

    // Allocate 0x10 -> 0x43 (target forced to 0x40); same-cycle lookup sees old contents
    bus.ihit = 1'b0;
    upd(32'h10, 1'b1, 32'h43);
    #1;
    chk("nobypass_pt", {31'b0, bus.pred_taken}, 32'h0);
    tick(); no_upd();
    chk("hold_noihit", bus.i_addr, 32'h10);
    chk("alloc_pt", {31'b0, bus.pred_taken}, 32'h1);
    chk("alloc_tgt", bus.pred_target, 32'h40);
    bus.ihit = 1'b1;
    tick(); bus.ihit = 1'b0;
    chk("follow_pred", bus.i_addr, 32'h40);
    chk("empty_pt", {31'b0, bus.pred_taken}, 32'h0);

    // Not-taken (low bits ignored) with redirect back to 0x10: ctr 10->01
    upd(32'h12, 1'b0, 32'h0); redir(32'h10);
    tick(); no_upd(); no_redir();
    chk("redir_10", bus.i_addr, 32'h10);
    chk("wnt_pt", {31'b0, bus.pred_taken}, 32'h0);
    chk("wnt_tgt", bus.pred_target, 32'h14);
    upd(32'h10, 1'b0, 32'h0); tick();   // 01 -> 00
    tick(); no_upd();                   // 00 stays 00
    chk("snt_pt", {31'b0, bus.pred_taken}, 32'h0);
    upd(32'h10, 1'b1, 32'h80); tick(); no_upd();   // 00 -> 01
    chk("sat_lo_pt", {31'b0, bus.pred_taken}, 32'h0);
    upd(32'h10, 1'b1, 32'h80); tick(); no_upd();   // 01 -> 10
    chk("rise_pt", {31'b0, bus.pred_taken}, 32'h1);
    chk("rise_tgt", bus.pred_target, 32'h80);
    upd(32'h10, 1'b1, 32'h80); tick(); tick();     // 10 -> 11 -> 11
    upd(32'h10, 1'b0, 32'h0); tick(); no_upd();    // 11 -> 10
    chk("sat_hi_pt", {31'b0, bus.pred_taken}, 32'h1);
    bus.ihit = 1'b1;
    tick(); bus.ihit = 1'b0;
    chk("follow_80", bus.i_addr, 32'h80);

    // Alias: 0x50 shares index 4 with 0x10
    upd(32'h50, 1'b1, 32'h100); redir(32'h10);
    tick(); no_upd(); no_redir();
    chk("alias_10_pt", {31'b0, bus.pred_taken}, 32'h0);
    chk("alias_10_tgt", bus.pred_target, 32'h14);
    redir(32'h50); tick(); no_redir();
    chk("alias_50_pt", {31'b0, bus.pred_taken}, 32'h1);
    chk("alias_50_tgt", bus.pred_target, 32'h100);

    // Redirect overrides stall/no-ihit; coincident update still written
    bus.stall = 1'b1;
    redir(32'h203); upd(32'h200, 1'b1, 32'h300);
    tick(); no_redir(); no_upd();
    chk("redir_stall", bus.i_addr, 32'h200);
    chk("redir_upd_pt", {31'b0, bus.pred_taken}, 32'h1);
    chk("redir_upd_tgt", bus.pred_target, 32'h300);
    bus.ihit = 1'b1;
    tick();
    chk("stall_hold", bus.i_addr, 32'h200);
    bus.stall = 1'b0; bus.ihit = 1'b0;

    // Wrap at top of address space
    redir(32'hFFFF_FFFF); tick(); no_redir();
    chk("wrap_addr", bus.i_addr, 32'hFFFF_FFFC);
    chk("wrap_tgt", bus.pred_target, 32'h0);
    bus.ihit = 1'b1;
    tick(); bus.ihit = 1'b0;
    chk("wrap_0", bus.i_addr, 32'h0);

    // Retrain 0x10, then async reset mid-cycle
    upd(32'h10, 1'b1, 32'h40); redir(32'h10);
    tick(); no_upd(); no_redir();
    chk("retrain_pt", {31'b0, bus.pred_taken}, 32'h1);
    #2;
    nRST = 1'b0;
    #1;
    chk("mid_rst_addr", bus.i_addr, 32'h0);
    chk("mid_rst_pt", {31'b0, bus.pred_taken}, 32'h0);
    tick();
    nRST = 1'b1;
    redir(32'h10); tick(); no_redir();
    chk("post_rst_addr", bus.i_addr, 32'h10);
    chk("post_rst_pt", {31'b0, bus.pred_taken}, 32'h0);
    chk("post_rst_tgt", bus.pred_target, 32'h14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
Parametrised fetch-stage program counter with an integrated direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. Each cycle it presents the fetch address and predicts the next PC. Execute-stage resolution feeds back a redirect and a training update. It replaces the fixed add4/jump/jr/branch selector: all non-sequential targets now arrive via prediction or redirect.

Parameters:
PC_W, 32, PC and target width in bits; minimum 8.
BTB_DEPTH, 16, number of BTB entries; power of 2, minimum 2.
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  instruction fetch for i_addr accepted this cycle
stall  in  1  pipeline freeze; hold PC
i_addr  out  PC_W  current fetch address
pred_taken  out  1  BTB hit with counter[1]=1 for i_addr
pred_target  out  PC_W  predicted next PC for i_addr (target if pred_taken, else i_addr+4)
redirect_valid  in  1  EX detected mispredict or unpredicted jump; flush fetch
redirect_pc  in  PC_W  correct next PC
update_valid  in  1  train BTB with a resolved control-flow instruction
update_pc  in  PC_W  address of the resolved instruction
update_taken  in  1  resolved direction
update_target  in  PC_W  resolved taken target

Behaviour:
- Reset (async): i_addr=RESET_PC; all BTB valid bits=0. pred_taken=0 and pred_target=RESET_PC+4 follow combinationally.
- IDX_W=log2(BTB_DEPTH). index=pc[IDX_W+1:2]; tag=pc[PC_W-1:IDX_W+2].
- Entry contents: valid, tag, target (PC_W), ctr (2 bits).
- Lookup is combinational on i_addr. Hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = pred_taken ? target : i_addr+4.
- Next-PC priority at posedge, highest first:
  - redirect_valid: i_addr <= {redirect_pc[PC_W-1:2],2'b00}. Overrides stall and ihit.
  - stall || !ihit: hold.
  - Otherwise: i_addr <= pred_target.
- i_addr[1:0] is always 0. +4 wraps modulo 2^PC_W, so all-ones-minus-3 goes to 0.
- Training on update_valid, written at posedge, one-cycle latency:
  - Hit, taken: ctr saturating +1 (max 11); target <= update_target.
  - Hit, not taken: ctr saturating -1 (min 00); target unchanged.
  - Miss, taken: allocate, overwriting any prior entry at that index. Set valid=1, tag, target, ctr=10 (weakly taken).
  - Miss, not taken: no change.
- Same-cycle lookup and update on one index: the lookup uses the pre-update contents; no bypass.
- Update and redirect are independent and may coincide. Both take effect at the same edge.
- update_pc and update_target bits [1:0] are ignored; the stored target is forced word-aligned.
- Reset mid-operation: valid bits and PC are cleared immediately; tag, target and ctr storage need not be reset.

Decomposition:
- Shared package diaosi_types_pkg gains:
  - ctr_t (2-bit) with constants STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11.
  - Parametrised btb_entry_t struct {valid, tag, target, ctr}, or a macro, if the tool disallows parametrised structs.
- One sub-module, btb_table:
  - Storage array plus combinational read port.
  - Synchronous write port implementing the hit/allocate/counter-saturation rules.
- pc_predict_unit holds the PC register and next-PC mux.

Test Plan:
- Reset then ihit=1, stall=0, no updates for 4 cycles -> i_addr sequence 0,4,8,C,10; pred_taken=0 throughout.
- update_valid with update_pc=0x10, taken=1, target=0x40; later fetch reaches 0x10 -> pred_taken=1, pred_target=0x40, next i_addr=0x40; entry ctr=10.
- Three further not-taken updates at 0x10 -> ctr 10->01->00->00 (saturates); fetch at 0x10 gives pred_taken=0, next i_addr=0x14.
- Alias: BTB_DEPTH=16, allocate 0x10 then 0x50 (same index, different tag) -> 0x10 now misses and 0x50 hits.
- redirect_valid=1, redirect_pc=0x203, with stall=1 and ihit=0 in the same cycle -> i_addr=0x200 next cycle; update at that index in that cycle is still written.
- Wrap and reset: i_addr=0xFFFF_FFFC with ihit -> 0x0; assert nRST=0 mid-sequence -> i_addr=RESET_PC and a previously trained 0x10 no longer predicts.
